// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline.
// Holds the fetch-stage state encodings, the pipeline bubble constants and
// the default address width / reset PC used by the stage modules.
package core_pkg;

    localparam int unsigned DEF_ADDR_W   = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    // A bubble carries a zero instruction word and a cleared valid bit.
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic        BUBBLE_VALID = 1'b0;

    // Encodings are visible on the fetch_state debug port; keep them fixed.
    typedef enum logic [1:0] {
        StFetch    = 2'd0,
        StStall    = 2'd1,
        StRedirect = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_stage_pipe_if.sv
// Fetch-stage bus bundle.
// Groups the hazard/redirect controls, the instruction-memory read port and
// the IF/ID register outputs.
//   slave  : the fetch stage (consumes controls + imem data, drives addr/IF-ID)
//   master : the surrounding core / testbench
interface if_stage_pipe_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              hazard;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_addr;
    logic [ADDR_W-1:0] imem_addr;
    logic [ADDR_W-1:0] imem_rdata;
    logic [ADDR_W-1:0] if_id_pc;
    logic [ADDR_W-1:0] if_id_instr;
    logic              if_id_valid;

    modport slave (
        input  hazard, branch_taken, branch_addr, imem_rdata,
        output imem_addr, if_id_pc, if_id_instr, if_id_valid
    );

    modport master (
        output hazard, branch_taken, branch_addr, imem_rdata,
        input  imem_addr, if_id_pc, if_id_instr, if_id_valid
    );
endinterface

// File: rtl/if_id_reg.sv
// Generic pipeline register carrying pc/instr/valid between two stages.
// Ports:
//   clk, rst           clock, async active-low reset
//   freeze             hold current contents
//   flush              load a bubble (wins over freeze)
//   pc_in, instr_in    values captured on a normal advance (valid set to 1)
//   pc_out, instr_out, valid_out  registered contents
module if_id_reg
    import core_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] instr_in,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] instr_out,
    output logic              valid_out
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush) begin
            pc_d    = '0;
            instr_d = ADDR_W'(NOP_INSTR);
            valid_d = BUBBLE_VALID;
        end else if (!freeze) begin
            pc_d    = pc_in;
            instr_d = instr_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= '0;
            instr_q <= ADDR_W'(NOP_INSTR);
            valid_q <= BUBBLE_VALID;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_out    = pc_q;
    assign instr_out = instr_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/if_stage_pipe.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, drives the instruction-memory address and captures the fetched
// word plus PC+STEP into IF/ID. Priority per edge: branch_taken > hazard > fetch.
// Ports:
//   clk, rst     clock, async active-low reset
//   fetch_bus    hazard/branch controls, imem port and IF/ID outputs
//   fetch_state  last edge's action (FETCH/STALL/REDIRECT), debug
//   stall_count  saturating count of frozen cycles, debug
module if_stage_pipe
    import core_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter int unsigned       PC_STEP  = 4,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    if_stage_pipe_if.slave   fetch_bus,
    output logic [1:0]       fetch_state,
    output logic [CNT_W-1:0] stall_count
);

    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
    fetch_state_e      state_q, state_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    // Wraps modulo 2^ADDR_W by design.
    assign pc_inc = pc_q + ADDR_W'(PC_STEP);

    // Next state depends only on this edge's inputs, never on state_q, so the
    // unused encoding 2'd3 simply behaves like FETCH.
    always_comb begin
        pc_d        = pc_q;
        state_d     = StFetch;
        stall_cnt_d = stall_cnt_q;
        if (fetch_bus.branch_taken) begin
            pc_d    = fetch_bus.branch_addr;
            state_d = StRedirect;
        end else if (fetch_bus.hazard) begin
            state_d = StStall;
            if (stall_cnt_q != {CNT_W{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end else begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            state_q     <= StFetch;
            stall_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // flush outranks freeze inside the register, matching branch > hazard.
    if_id_reg #(
        .ADDR_W (ADDR_W)
    ) u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .freeze    (fetch_bus.hazard),
        .flush     (fetch_bus.branch_taken),
        .pc_in     (pc_inc),
        .instr_in  (fetch_bus.imem_rdata),
        .pc_out    (fetch_bus.if_id_pc),
        .instr_out (fetch_bus.if_id_instr),
        .valid_out (fetch_bus.if_id_valid)
    );

    assign fetch_bus.imem_addr = pc_q;
    assign fetch_state         = state_q;
    assign stall_count         = stall_cnt_q;

endmodule

// File: tb/tb_if_stage_pipe.sv
// Directed testbench for if_stage_pipe. Instruction memory is modelled as
// imem_rdata = 0xE0000000 | imem_addr. Stall counter built with CNT_W = 4.
module tb_if_stage_pipe;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 4;

    logic             clk;
    logic             rst;
    logic [1:0]       fetch_state;
    logic [CNT_W-1:0] stall_count;

    int n_vec = 0;
    int n_err = 0;

    if_stage_pipe_if #(.ADDR_W(ADDR_W)) bus ();

    assign bus.imem_rdata = 32'hE000_0000 | bus.imem_addr;

    if_stage_pipe #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_bus   (bus),
        .fetch_state (fetch_state),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " imem_addr"},   bus.imem_addr, 32'h0);
        check({tag, " if_id_pc"},    bus.if_id_pc, 32'h0);
        check({tag, " if_id_instr"}, bus.if_id_instr, 32'h0);
        check({tag, " if_id_valid"}, 32'(bus.if_id_valid), 32'h0);
        check({tag, " state"},       32'(fetch_state), 32'd0);
        check({tag, " stall_count"}, 32'(stall_count), 32'd0);
    endtask

    initial begin
        rst              = 1'b0;
        bus.hazard       = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_addr  = '0;
        #1;
        check_reset_state("rst0");
        #1 rst = 1'b1;

        // Free-running fetch: 4 cycles.
        for (int i = 0; i < 4; i++) begin
            check("run imem_addr", bus.imem_addr, 32'(4 * i));
            tick();
            check("run if_id_pc",    bus.if_id_pc, 32'(4 * (i + 1)));
            check("run if_id_instr", bus.if_id_instr, 32'hE000_0000 | 32'(4 * i));
            check("run if_id_valid", 32'(bus.if_id_valid), 32'd1);
            check("run state",       32'(fetch_state), 32'd0);
        end

        // Restart and stall at pc=8.
        rst = 1'b0;
        #1;
        check_reset_state("rst1");
        rst = 1'b1;
        tick();
        tick();
        check("pre-stall imem_addr", bus.imem_addr, 32'h8);
        bus.hazard = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("stall imem_addr",   bus.imem_addr, 32'h8);
            check("stall if_id_pc",    bus.if_id_pc, 32'h8);
            check("stall if_id_instr", bus.if_id_instr, 32'hE000_0004);
            check("stall if_id_valid", 32'(bus.if_id_valid), 32'd1);
            check("stall state",       32'(fetch_state), 32'd1);
            check("stall count",       32'(stall_count), 32'(k));
        end
        bus.hazard = 1'b0;
        tick();
        check("release if_id_pc",    bus.if_id_pc, 32'hC);
        check("release if_id_instr", bus.if_id_instr, 32'hE000_0008);
        check("release imem_addr",   bus.imem_addr, 32'hC);
        check("release state",       32'(fetch_state), 32'd0);
        check("release count",       32'(stall_count), 32'd3);

        // Branch beats a simultaneous hazard.
        bus.hazard       = 1'b1;
        bus.branch_taken = 1'b1;
        bus.branch_addr  = 32'h100;
        tick();
        check("br imem_addr",   bus.imem_addr, 32'h100);
        check("br if_id_valid", 32'(bus.if_id_valid), 32'd0);
        check("br if_id_instr", bus.if_id_instr, 32'h0);
        check("br if_id_pc",    bus.if_id_pc, 32'h0);
        check("br state",       32'(fetch_state), 32'd2);
        check("br count",       32'(stall_count), 32'd3);
        bus.hazard       = 1'b0;
        bus.branch_taken = 1'b0;
        tick();
        check("post-br if_id_pc",    bus.if_id_pc, 32'h104);
        check("post-br if_id_instr", bus.if_id_instr, 32'hE000_0100);
        check("post-br if_id_valid", 32'(bus.if_id_valid), 32'd1);
        check("post-br state",       32'(fetch_state), 32'd0);

        // PC wrap.
        bus.branch_taken = 1'b1;
        bus.branch_addr  = 32'hFFFF_FFFC;
        tick();
        check("wrap-br imem_addr", bus.imem_addr, 32'hFFFF_FFFC);
        bus.branch_taken = 1'b0;
        tick();
        check("wrap imem_addr",   bus.imem_addr, 32'h0);
        check("wrap if_id_pc",    bus.if_id_pc, 32'h0);
        check("wrap if_id_instr", bus.if_id_instr, 32'hFFFF_FFFC);
        check("wrap if_id_valid", 32'(bus.if_id_valid), 32'd1);

        // Counter saturation: starts at 3, reaches 15 after 12 stalls.
        bus.hazard = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 11) check("sat count 14", 32'(stall_count), 32'd14);
            if (k == 12) check("sat count 15", 32'(stall_count), 32'd15);
        end
        check("sat count held", 32'(stall_count), 32'd15);
        check("sat imem_addr",  bus.imem_addr, 32'h0);

        // Async reset mid-stall at pc=0x40.
        bus.hazard       = 1'b0;
        bus.branch_taken = 1'b1;
        bus.branch_addr  = 32'h40;
        tick();
        bus.branch_taken = 1'b0;
        bus.hazard       = 1'b1;
        tick();
        check("pre-rst imem_addr", bus.imem_addr, 32'h40);
        check("pre-rst state",     32'(fetch_state), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_reset_state("async");
        bus.hazard = 1'b0;
        #1 rst = 1'b1;
        check("resume imem_addr0", bus.imem_addr, 32'h0);
        tick();
        check("resume imem_addr",   bus.imem_addr, 32'h4);
        check("resume if_id_pc",    bus.if_id_pc, 32'h4);
        check("resume if_id_instr", bus.if_id_instr, 32'hE000_0000);
        check("resume if_id_valid", 32'(bus.if_id_valid), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
